// File: rtl/s3g_frame_sender.sv
// S3G frame transmitter: buffers a payload, then streams 0xD5, length, payload and
// Maxim CRC8 (payload only) through a tx_data/tx_wr/tx_done UART handshake.
module s3g_frame_sender #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_clear_i,
  input  logic             load_valid_i,
  input  logic [7:0]       load_data_i,
  input  logic             start_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_wr_o,
  input  logic             tx_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] count_o
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;
  typedef enum logic [1:0] {SEL_HDR, SEL_LEN, SEL_PAY, SEL_CRC} sel_e;

  state_e           state_q;
  sel_e             sel_q;
  logic [LEN_W-1:0] count_q, count_d, ptr_q;
  logic [7:0]       crc_q, tx_data_q, byte_d;
  logic             tx_wr_q, busy_q, done_q, err_q;
  logic             wr_en, ovf;
  logic [7:0]       mem_q [2**AW];

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 8'h8C) : (x >> 1);
    return x;
  endfunction

  // Load action resolves first so a same-cycle start sees the updated count.
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    ovf     = 1'b0;
    if (state_q == S_IDLE) begin
      if (load_clear_i) begin
        count_d = '0;
      end else if (load_valid_i) begin
        if (count_q == LEN_W'(MAX_LEN)) begin
          ovf = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + LEN_W'(1);
        end
      end
    end
  end

  always_comb begin
    byte_d = 8'hD5;
    case (sel_q)
      SEL_HDR: byte_d = 8'hD5;
      SEL_LEN: byte_d = 8'(count_q);
      SEL_PAY: byte_d = mem_q[ptr_q[AW-1:0]];
      SEL_CRC: byte_d = crc_q;
      default: byte_d = 8'hD5;
    endcase
  end

  // Payload storage needs no reset; contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= load_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= SEL_HDR;
      count_q   <= '0;
      ptr_q     <= '0;
      crc_q     <= 8'h00;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tx_wr_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          count_q <= count_d;
          err_q   <= ovf | (start_i && count_d == '0);
          if (start_i && count_d != '0) begin
            busy_q  <= 1'b1;
            crc_q   <= 8'h00;
            ptr_q   <= '0;
            sel_q   <= SEL_HDR;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          tx_wr_q   <= 1'b1;
          tx_data_q <= byte_d;
          if (sel_q == SEL_PAY) crc_q <= crc8(crc_q, mem_q[ptr_q[AW-1:0]]);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_i) begin
            state_q <= S_SEND;
            case (sel_q)
              SEL_HDR: sel_q <= SEL_LEN;
              SEL_LEN: sel_q <= SEL_PAY;
              SEL_PAY: begin
                if (ptr_q == count_q - LEN_W'(1)) sel_q <= SEL_CRC;
                else ptr_q <= ptr_q + LEN_W'(1);
              end
              default: begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_wr_o   = tx_wr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign count_o   = count_q;

endmodule
